// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate format encodings and RV opcode constants
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_Z     = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // SLLI/SRLI/SRAI carry a shift amount instead of a signed immediate
    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// rtl/imm_decode_stage_if.sv - upstream/downstream handshake bundle of the immediate-decode stage
interface imm_decode_stage_if
    import imm_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instruction;
    logic [XLEN-1:0] i_pc;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_immediate;
    logic [XLEN-1:0] o_target;
    imm_fmt_e        o_format;
    logic            o_illegal;

    modport master (
        output i_flush, i_valid, i_instruction, i_pc, i_ready,
        input  o_ready, o_valid, o_immediate, o_target, o_format, o_illegal
    );

    modport slave (
        input  i_flush, i_valid, i_instruction, i_pc, i_ready,
        output o_ready, o_valid, o_immediate, o_target, o_format, o_illegal
    );
endinterface

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational instruction word to immediate/format/illegal decoder
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit ENABLE_64 = 1'b0
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [5:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    // RV64 shifts use a 6-bit shamt; instr[25] belongs to funct7 on RV32
    assign shamt  = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (is_shift(funct3)) begin
                    fmt = FMT_SHAMT;
                    imm = XLEN'(shamt);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_OP_IMM_32: begin
                if (!ENABLE_64) begin
                    illegal = 1'b1;
                end else if (is_shift(funct3)) begin
                    fmt = FMT_SHAMT;
                    imm = XLEN'(instr[24:20]);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt = FMT_I;
                imm = XLEN'($signed(instr[31:20]));
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    fmt = FMT_Z;
                    imm = XLEN'(instr[19:15]);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate decode + PC-relative target stage with valid/ready and flush
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit ENABLE_64 = 1'b0
) (
    input logic               i_clk,
    input logic               i_reset,
    imm_decode_stage_if.slave bus
);
    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end
    if (ENABLE_64 && XLEN != 64) begin : g_bad_enable_64
        $error("imm_decode_stage: ENABLE_64 requires XLEN == 64");
    end

    logic [XLEN-1:0] ext_imm;
    imm_fmt_e        ext_fmt;
    logic            ext_illegal;

    logic            valid_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] target_q;
    imm_fmt_e        fmt_q;
    logic            illegal_q;
    logic            ready;
    logic            accept;

    imm_extract #(
        .XLEN      (XLEN),
        .ENABLE_64 (ENABLE_64)
    ) u_extract (
        .instr   (bus.i_instruction),
        .imm     (ext_imm),
        .fmt     (ext_fmt),
        .illegal (ext_illegal)
    );

    assign ready  = !valid_q || bus.i_ready;
    assign accept = bus.i_valid && ready;

    // Data registers only move on accept, so a stalled entry stays bit-stable
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q   <= 1'b0;
            imm_q     <= '0;
            target_q  <= '0;
            fmt_q     <= FMT_NONE;
            illegal_q <= 1'b0;
        end else if (bus.i_flush) begin
            valid_q   <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            imm_q     <= ext_imm;
            target_q  <= bus.i_pc + ext_imm;
            fmt_q     <= ext_fmt;
            illegal_q <= ext_illegal;
        end else if (bus.i_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = valid_q;
    assign bus.o_immediate = imm_q;
    assign bus.o_target    = target_q;
    assign bus.o_format    = fmt_q;
    assign bus.o_illegal   = illegal_q;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - scoreboard bench for imm_decode_stage (XLEN=32 and XLEN=64/ENABLE_64 instances)
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32)) b32 ();
    imm_decode_stage_if #(.XLEN(64)) b64 ();

    imm_decode_stage #(.XLEN(32), .ENABLE_64(1'b0)) dut32 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (b32.slave)
    );

    imm_decode_stage #(.XLEN(64), .ENABLE_64(1'b1)) dut64 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (b64.slave)
    );

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        imm_fmt_e    fmt;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        imm_fmt_e    fmt;
        logic        ill;
    } vec_t;

    exp_t q32[$];
    exp_t q64[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && b32.o_valid === 1'b1 && b32.i_ready === 1'b1) begin
            if (q32.size() == 0) begin
                chk("out32_unexpected", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                chk("out32_imm", 64'(b32.o_immediate), e.imm);
                chk("out32_target", 64'(b32.o_target), e.tgt);
                chk("out32_format", 64'(b32.o_format), 64'(e.fmt));
                chk("out32_illegal", 64'(b32.o_illegal), 64'(e.ill));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && b64.o_valid === 1'b1 && b64.i_ready === 1'b1) begin
            if (q64.size() == 0) begin
                chk("out64_unexpected", 64'd1, 64'd0);
            end else begin
                e = q64.pop_front();
                chk("out64_imm", b64.o_immediate, e.imm);
                chk("out64_target", b64.o_target, e.tgt);
                chk("out64_format", 64'(b64.o_format), 64'(e.fmt));
                chk("out64_illegal", 64'(b64.o_illegal), 64'(e.ill));
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the posedge that took the word
    task automatic send32(input vec_t v, output int waited);
        exp_t e;
        bit   accepted;
        accepted          = 1'b0;
        waited            = 0;
        b32.i_valid       = 1'b1;
        b32.i_instruction = v.ins;
        b32.i_pc          = v.pc[31:0];
        e.imm = v.imm; e.tgt = v.tgt; e.fmt = v.fmt; e.ill = v.ill;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b32.o_ready === 1'b1) begin
                q32.push_back(e);
                accepted = 1'b1;
                break;
            end
            waited++;
            @(posedge clk); #1;
        end
        if (!accepted) chk("send32_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        b32.i_valid = 1'b0;
    endtask

    task automatic send64(input vec_t v, output int waited);
        exp_t e;
        bit   accepted;
        accepted          = 1'b0;
        waited            = 0;
        b64.i_valid       = 1'b1;
        b64.i_instruction = v.ins;
        b64.i_pc          = v.pc;
        e.imm = v.imm; e.tgt = v.tgt; e.fmt = v.fmt; e.ill = v.ill;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b64.o_ready === 1'b1) begin
                q64.push_back(e);
                accepted = 1'b1;
                break;
            end
            waited++;
            @(posedge clk); #1;
        end
        if (!accepted) chk("send64_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        b64.i_valid = 1'b0;
    endtask

    vec_t v32[] = '{
        '{32'hFFF00093, 64'h0,        64'hFFFFFFFF, 64'hFFFFFFFF, FMT_I,     1'b0},
        '{32'hFE112E23, 64'h200,      64'hFFFFFFFC, 64'h000001FC, FMT_S,     1'b0},
        '{32'h123452B7, 64'h10,       64'h12345000, 64'h12345010, FMT_U,     1'b0},
        '{32'hFF9FF06F, 64'h100,      64'hFFFFFFF8, 64'h000000F8, FMT_J,     1'b0},
        '{32'h00000463, 64'hFFFFFFFC, 64'h00000008, 64'h00000004, FMT_B,     1'b0},
        '{32'h0000007F, 64'h40,       64'h0,        64'h00000040, FMT_NONE,  1'b1},
        '{32'h00309093, 64'h0,        64'h3,        64'h3,        FMT_SHAMT, 1'b0},
        '{32'h4050D093, 64'h0,        64'h5,        64'h5,        FMT_SHAMT, 1'b0},
        '{32'h300FD073, 64'h0,        64'h1F,       64'h1F,       FMT_Z,     1'b0},
        '{32'hFFFFF017, 64'h2000,     64'hFFFFF000, 64'h00001000, FMT_U,     1'b0},
        '{32'h0000001B, 64'h8,        64'h0,        64'h8,        FMT_NONE,  1'b1},
        '{32'hFFC12283, 64'h0,        64'hFFFFFFFC, 64'hFFFFFFFC, FMT_I,     1'b0}
    };

    vec_t v64[] = '{
        '{32'h03F09093, 64'h0,  64'd63,                 64'd63,                 FMT_SHAMT, 1'b0},
        '{32'hFFF00093, 64'h10, 64'hFFFFFFFF_FFFFFFFF,  64'h0000000F,           FMT_I,     1'b0},
        '{32'h0030909B, 64'h0,  64'd3,                  64'd3,                  FMT_SHAMT, 1'b0},
        '{32'hFFF0809B, 64'h0,  64'hFFFFFFFF_FFFFFFFF,  64'hFFFFFFFF_FFFFFFFF,  FMT_I,     1'b0},
        '{32'h800000B7, 64'h0,  64'hFFFFFFFF_80000000,  64'hFFFFFFFF_80000000,  FMT_U,     1'b0},
        '{32'h0000007F, 64'h4,  64'h0,                  64'h4,                  FMT_NONE,  1'b1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        b32.i_flush = 1'b0; b32.i_valid = 1'b0; b32.i_instruction = '0; b32.i_pc = '0; b32.i_ready = 1'b1;
        b64.i_flush = 1'b0; b64.i_valid = 1'b0; b64.i_instruction = '0; b64.i_pc = '0; b64.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_o_valid", 64'(b32.o_valid), 64'd0);
        chk("reset_o_immediate", 64'(b32.o_immediate), 64'd0);
        chk("reset_o_target", 64'(b32.o_target), 64'd0);
        chk("reset_o_format", 64'(b32.o_format), 64'(FMT_NONE));
        chk("reset_o_illegal", 64'(b32.o_illegal), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // back-to-back stream: every word after the first must be taken without waiting
        foreach (v32[i]) begin
            send32(v32[i], w);
            chk("b2b_no_wait", 64'(w), 64'd0);
        end
        repeat (2) @(posedge clk); #1;

        // stall: entry held for 3 cycles while the next word waits upstream
        b32.i_ready = 1'b0;
        send32(v32[0], w);
        b32.i_valid = 1'b1; b32.i_instruction = v32[2].ins; b32.i_pc = v32[2].pc[31:0];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_o_valid", 64'(b32.o_valid), 64'd1);
            chk("stall_o_immediate", 64'(b32.o_immediate), 64'hFFFFFFFF);
            chk("stall_o_ready", 64'(b32.o_ready), 64'd0);
            @(posedge clk); #1;
        end
        b32.i_ready = 1'b1;
        send32(v32[2], w);
        repeat (2) @(posedge clk); #1;

        // flush with an incoming word: word is dropped
        b32.i_valid = 1'b1; b32.i_flush = 1'b1; b32.i_instruction = v32[3].ins; b32.i_pc = v32[3].pc[31:0];
        @(posedge clk); #1;
        b32.i_valid = 1'b0; b32.i_flush = 1'b0;
        @(negedge clk);
        chk("flush_in_o_valid", 64'(b32.o_valid), 64'd0);
        @(posedge clk); #1;

        // flush of a stalled entry
        b32.i_ready = 1'b0;
        send32(v32[1], w);
        b32.i_flush = 1'b1;
        void'(q32.pop_back());
        @(posedge clk); #1;
        b32.i_flush = 1'b0;
        @(negedge clk);
        chk("flush_held_o_valid", 64'(b32.o_valid), 64'd0);
        chk("flush_held_o_ready", 64'(b32.o_ready), 64'd1);
        @(posedge clk); #1;

        // reset while stalled discards the held entry
        send32(v32[3], w);
        rst = 1'b1;
        q32.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall_o_valid", 64'(b32.o_valid), 64'd0);
        chk("rst_stall_o_immediate", 64'(b32.o_immediate), 64'd0);
        chk("rst_stall_o_target", 64'(b32.o_target), 64'd0);
        chk("rst_stall_o_format", 64'(b32.o_format), 64'(FMT_NONE));
        chk("rst_stall_o_illegal", 64'(b32.o_illegal), 64'd0);
        chk("rst_stall_o_ready", 64'(b32.o_ready), 64'd1);
        @(posedge clk); #1;
        b32.i_ready = 1'b1;
        send32(v32[4], w);
        repeat (2) @(posedge clk); #1;

        foreach (v64[i]) send64(v64[i], w);
        repeat (3) @(posedge clk); #1;

        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
